// File: rtl/sub_pkg.sv
// Shared definitions for the sequential digit-serial subtractor.
// Holds the FSM state type, default geometry and the full-adder cell.
package sub_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGIT  = 4;
    localparam int unsigned STEPS  = WIDTH / DIGIT;
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract stage: d = x + ~y + cin.
// Ripple of full-adder cells with the subtrahend inverted.
module sub_digit
    import sub_pkg::*;
#(
    parameter int unsigned DIGIT = sub_pkg::DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] d,
    output logic             cout
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        d    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            {c[i+1], d[i]} = full_add(x[i], ~y[i], c[i]);
        end
        cout = c[DIGIT];
    end

endmodule

// File: rtl/sub_16bit_seq.sv
// Digit-serial subtractor a - b with valid/ready handshake and adder-style flags.
// One DIGIT-bit slice per clock, LSB first; result and flags registered on completion.
module sub_16bit_seq
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = sub_pkg::WIDTH,
    parameter int unsigned DIGIT = sub_pkg::DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             parity,
    output logic             overflow,
    output logic             sign,
    output logic             zero
);

    localparam int unsigned NSTEP = WIDTH / DIGIT;
    localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d, parity_q, parity_d;
    logic             overflow_q, overflow_d, sign_q, sign_d, zero_q, zero_d;

    logic [DIGIT-1:0] dig_x, dig_y, dig_d;
    logic             dig_cout;

    assign dig_x = a_q[step_q*DIGIT +: DIGIT];
    assign dig_y = b_q[step_q*DIGIT +: DIGIT];

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (dig_x),
        .y    (dig_y),
        .cin  (carry_q),
        .d    (dig_d),
        .cout (dig_cout)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        a_d        = a_q;
        b_d        = b_q;
        part_d     = part_q;
        carry_d    = carry_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        parity_d   = parity_q;
        overflow_d = overflow_q;
        sign_d     = sign_q;
        zero_d     = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    part_d  = '0;
                    carry_d = 1'b1;
                    step_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                part_d[step_q*DIGIT +: DIGIT] = dig_d;
                carry_d = dig_cout;
                step_d  = step_q + SW'(1);
                // Flags come from the completed word, including the digit written this edge.
                if (step_q == SW'(NSTEP - 1)) begin
                    state_d    = DONE;
                    diff_d     = part_d;
                    borrow_d   = ~dig_cout;
                    parity_d   = ^part_d;
                    overflow_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (part_d[WIDTH-1] ^ a_q[WIDTH-1]);
                    sign_d     = part_d[WIDTH-1];
                    zero_d     = ~|part_d;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            part_q     <= '0;
            carry_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            parity_q   <= 1'b0;
            overflow_q <= 1'b0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            a_q        <= a_d;
            b_q        <= b_d;
            part_q     <= part_d;
            carry_q    <= carry_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            parity_q   <= parity_d;
            overflow_q <= overflow_d;
            sign_q     <= sign_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign parity    = parity_q;
    assign overflow  = overflow_q;
    assign sign      = sign_q;
    assign zero      = zero_q;

endmodule
